// File: rtl/nco_quarter_lut.sv
// nco_quarter_lut: phase-accumulator NCO front end.
// Splits the accumulated phase into a quadrant code and an in-quadrant index,
// reads a quarter-wave sine ROM at the index and its mirror, and emits
// time-aligned first-quadrant magnitudes plus the quadrant sign code.
module nco_quarter_lut #(
  parameter int    PHASE_W  = 32,
  parameter int    LUT_AW   = 10,
  parameter int    AMP_W    = 17,
  parameter string LUT_FILE = "quarter_sin.hex"
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [PHASE_W-1:0] fcw,
  input  logic               phase_load,
  input  logic [PHASE_W-1:0] phase_init,
  output logic [AMP_W-1:0]   sin_a,
  output logic [AMP_W-1:0]   cos_a,
  output logic [1:0]         qwadrant,
  output logic               valid
);

  localparam int N = 2**LUT_AW;

  // Quarter-wave table, read-only after initialisation.
  logic [AMP_W-1:0] rom [N];

  // Table built from the sine formula.
  initial begin
    for (int k = 0; k < N; k++) begin
      rom[k] = AMP_W'($rtoi(real'(2**AMP_W - 1) *
               $sin((real'(k) + 0.5) * 3.14159265358979323846 / real'(2 * N)) + 0.5));
    end
  end

  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [1:0]         p;
  logic [LUT_AW-1:0]  r;
  logic               v1_q, v1_d;
  logic [1:0]         q1_q, q1_d;
  logic               swap1_q, swap1_d;
  logic [LUT_AW-1:0]  addr_a_q, addr_a_d;
  logic [LUT_AW-1:0]  addr_b_q, addr_b_d;
  logic [AMP_W-1:0]   ra_q, ra_d;
  logic [AMP_W-1:0]   rb_q, rb_d;
  logic               v2_q, v2_d;
  logic [1:0]         q2_q, q2_d;
  logic               swap2_q, swap2_d;
  logic [AMP_W-1:0]   sin_q, sin_d;
  logic [AMP_W-1:0]   cos_q, cos_d;
  logic [1:0]         quad_q, quad_d;
  logic               valid_q, valid_d;

  // Accumulator: load wins over advance; wrap is silent modulo 2**PHASE_W.
  always_comb begin
    acc_d = acc_q;
    if (phase_load) begin
      acc_d = phase_init;
    end else if (en) begin
      acc_d = acc_q + fcw;
    end
  end

  // Stage 1: split the pre-update phase into quadrant, index and mirror index.
  always_comb begin
    p        = acc_q[PHASE_W-1 -: 2];
    r        = acc_q[PHASE_W-3 -: LUT_AW];
    v1_d     = en & ~phase_load;
    q1_d     = 2'd0 - p;      // (4 - p) & 3: odd quadrants swap code order
    swap1_d  = p[0];
    addr_a_d = r;
    addr_b_d = ~r;            // N-1-r
  end

  // Stage 2: dual ROM read, control delayed alongside.
  always_comb begin
    ra_d    = rom[addr_a_q];
    rb_d    = rom[addr_b_q];
    v2_d    = v1_q;
    q2_d    = q1_q;
    swap2_d = swap1_q;
  end

  // Stage 3: odd quadrants exchange the sin and cos magnitudes.
  always_comb begin
    sin_d   = swap2_q ? rb_q : ra_q;
    cos_d   = swap2_q ? ra_q : rb_q;
    quad_d  = q2_q;
    valid_d = v2_q;
  end

  // All state registers; synchronous active-low reset clears everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      v1_q     <= 1'b0;
      q1_q     <= '0;
      swap1_q  <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      v2_q     <= 1'b0;
      q2_q     <= '0;
      swap2_q  <= 1'b0;
      sin_q    <= '0;
      cos_q    <= '0;
      quad_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      v1_q     <= v1_d;
      q1_q     <= q1_d;
      swap1_q  <= swap1_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      v2_q     <= v2_d;
      q2_q     <= q2_d;
      swap2_q  <= swap2_d;
      sin_q    <= sin_d;
      cos_q    <= cos_d;
      quad_q   <= quad_d;
      valid_q  <= valid_d;
    end
  end

  assign sin_a    = sin_q;
  assign cos_a    = cos_q;
  assign qwadrant = quad_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_nco_quarter_lut.sv
// tb_nco_quarter_lut: table-driven vectors plus hand-written sequences,
// checked through an expected-sample queue keyed on the output cycle.
module tb_nco_quarter_lut;

  localparam int PHASE_W = 32;
  localparam int LUT_AW  = 10;
  localparam int AMP_W   = 17;
  localparam int N       = 1024;
  localparam logic [31:0] Q = 32'h4000_0000;  // quarter turn
  localparam logic [31:0] K = 32'h0010_0000;  // one ROM index

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0;
  logic [PHASE_W-1:0] fcw = '0;
  logic               phase_load = 1'b0;
  logic [PHASE_W-1:0] phase_init = '0;
  logic [AMP_W-1:0]   sin_a;
  logic [AMP_W-1:0]   cos_a;
  logic [1:0]         qwadrant;
  logic               valid;

  nco_quarter_lut #(
    .PHASE_W (PHASE_W),
    .LUT_AW  (LUT_AW),
    .AMP_W   (AMP_W),
    .LUT_FILE("")
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .fcw       (fcw),
    .phase_load(phase_load),
    .phase_init(phase_init),
    .sin_a     (sin_a),
    .cos_a     (cos_a),
    .qwadrant  (qwadrant),
    .valid     (valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               due;
    logic [AMP_W-1:0] s;
    logic [AMP_W-1:0] c;
    logic [1:0]       q;
  } exp_t;

  typedef struct {
    bit          r;
    bit          e;
    bit          l;
    logic [31:0] init;
    logic [31:0] f;
    bit          iss;
    int          si;
    int          ci;
    logic [1:0]  q;
  } vec_t;

  exp_t             sb[$];
  vec_t             tbl[$];
  logic [AMP_W-1:0] S [N];
  int               cyc = 0;
  int               n_chk = 0;
  int               n_pass = 0;
  int               n_dut_valid = 0;
  bit               rst_prev = 1'b1;
  bit               sweep_mode = 1'b0;

  function automatic vec_t mk(bit r, bit e, bit l, logic [31:0] init, logic [31:0] f,
                              bit iss, int si, int ci, logic [1:0] q);
    vec_t v;
    v.r = r; v.e = e; v.l = l; v.init = init; v.f = f;
    v.iss = iss; v.si = si; v.ci = ci; v.q = q;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h want %0h", name, cyc, act, req);
  endtask

  // Compare the outputs visible in this cycle against the queue head.
  task automatic observe();
    bit   exp_v;
    exp_t e;
    real  m;
    exp_v = (sb.size() > 0) && (sb[0].due == cyc);
    check("valid", {31'd0, valid}, {31'd0, exp_v});
    if (valid === 1'b1) n_dut_valid++;
    if (exp_v) begin
      e = sb.pop_front();
      check("sin_a", {15'd0, sin_a}, {15'd0, e.s});
      check("cos_a", {15'd0, cos_a}, {15'd0, e.c});
      check("qwadrant", {30'd0, qwadrant}, {30'd0, e.q});
      if (sweep_mode) begin
        m = $sqrt(real'(sin_a) * real'(sin_a) + real'(cos_a) * real'(cos_a));
        n_chk++;
        if (m >= 131070.0 && m <= 131072.0) n_pass++;
        else $display("FAIL magnitude cycle %0d: got %f want 131071 +/- 1", cyc, m);
      end
    end
    if (rst_prev) begin
      check("rst_sin_a", {15'd0, sin_a}, 32'd0);
      check("rst_cos_a", {15'd0, cos_a}, 32'd0);
      check("rst_qwadrant", {30'd0, qwadrant}, 32'd0);
    end
  endtask

  // One cycle: check outputs, then drive the next inputs and record the expected sample.
  task automatic step(input bit r, input bit e, input bit l, input logic [31:0] init,
                      input logic [31:0] f, input bit iss, input int si, input int ci,
                      input logic [1:0] q);
    exp_t x;
    @(negedge clk);
    observe();
    rst_n = r; en = e; phase_load = l; phase_init = init; fcw = f;
    if (!r) begin
      sb.delete();
    end else if (iss) begin
      x.due = cyc + 3; x.s = S[si]; x.c = S[ci]; x.q = q;
      sb.push_back(x);
    end
    rst_prev = !r;
    cyc++;
  endtask

  logic [31:0] acc_m;
  logic [1:0]  pm;
  int          rm;

  initial begin
    for (int k = 0; k < N; k++)
      S[k] = AMP_W'($rtoi(131071.0 * $sin((real'(k) + 0.5) * 3.14159265358979323846 / 2048.0) + 0.5));

    // Reset with en high: nothing issued.
    tbl.push_back(mk(0, 1, 0, 0, Q, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, Q, 0, 0, 0, 0));
    // Quarter steps from acc=0, two full turns.
    for (int t = 0; t < 2; t++) begin
      tbl.push_back(mk(1, 1, 0, 0, Q, 1, 0, 1023, 2'd0));
      tbl.push_back(mk(1, 1, 0, 0, Q, 1, 1023, 0, 2'd3));
      tbl.push_back(mk(1, 1, 0, 0, Q, 1, 0, 1023, 2'd2));
      tbl.push_back(mk(1, 1, 0, 0, Q, 1, 1023, 0, 2'd1));
    end
    tbl.push_back(mk(1, 0, 0, 0, Q, 0, 0, 0, 0));
    // Wrap through zero.
    tbl.push_back(mk(1, 1, 1, 32'hFFFF_FFF0, 32'h20, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 32'h20, 1, 0, 1023, 2'd1));
    tbl.push_back(mk(1, 1, 0, 0, 32'h20, 1, 0, 1023, 2'd0));
    tbl.push_back(mk(1, 1, 0, 0, 32'h20, 1, 0, 1023, 2'd0));
    // Load beats en; next en samples phase_init; fcw change applies after.
    tbl.push_back(mk(1, 1, 1, 32'h8000_0000, 32'h20, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 32'h0, 1, 0, 1023, 2'd2));
    tbl.push_back(mk(1, 1, 0, 0, 32'h0, 1, 0, 1023, 2'd2));
    tbl.push_back(mk(1, 1, 0, 0, K, 1, 0, 1023, 2'd2));
    tbl.push_back(mk(1, 1, 0, 0, K, 1, 1, 1022, 2'd2));
    // Gated issue 1,0,1,1,0 then 1: index advances only on en.
    tbl.push_back(mk(1, 0, 1, 32'h0, K, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, K, 1, 0, 1023, 2'd0));
    tbl.push_back(mk(1, 0, 0, 0, K, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, K, 1, 1, 1022, 2'd0));
    tbl.push_back(mk(1, 1, 0, 0, K, 1, 2, 1021, 2'd0));
    tbl.push_back(mk(1, 0, 0, 0, K, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, K, 1, 3, 1020, 2'd0));
    // Odd quadrant with nonzero index: mirror lands on sin.
    tbl.push_back(mk(1, 0, 1, 32'h4030_0000, K, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, K, 1, 1020, 3, 2'd3));
    tbl.push_back(mk(1, 1, 0, 0, K, 1, 1019, 4, 2'd3));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 0, 0, K, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].r, tbl[i].e, tbl[i].l, tbl[i].init, tbl[i].f,
           tbl[i].iss, tbl[i].si, tbl[i].ci, tbl[i].q);

    // Mid-stream reset drops the in-flight samples; restart from acc=0.
    step(1, 0, 1, 32'h0, K, 0, 0, 0, 0);
    step(1, 1, 0, 0, K, 1, 0, 1023, 2'd0);
    step(1, 1, 0, 0, K, 1, 1, 1022, 2'd0);
    step(1, 1, 0, 0, K, 1, 2, 1021, 2'd0);
    step(0, 1, 0, 0, K, 0, 0, 0, 0);
    step(1, 1, 0, 0, K, 1, 0, 1023, 2'd0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, K, 0, 0, 0, 0);

    // Full-turn sweep, one ROM index per sample.
    step(0, 0, 0, 0, K, 0, 0, 0, 0);
    sweep_mode = 1'b1;
    n_dut_valid = 0;
    acc_m = '0;
    for (int i = 0; i < 4 * N; i++) begin
      pm = acc_m[31:30];
      rm = int'(acc_m[29:20]);
      step(1, 1, 0, 0, K, 1, pm[0] ? (N - 1 - rm) : rm, pm[0] ? rm : (N - 1 - rm), 2'd0 - pm);
      acc_m = acc_m + K;
    end
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, K, 0, 0, 0, 0);
    check("sweep_count", n_dut_valid, 4 * N);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
